// File: rtl/mc_ctrl.sv
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multicycle MIPS control FSM. Sequences the fetch, decode,
//                execute, memory and write-back states and drives the
//                datapath write enables and mux selects.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       irwr,
    output logic       pcwr,
    output logic [1:0] npc_sel,
    output logic       rfwr,
    output logic [1:0] rf_wsel,
    output logic [1:0] rf_dsel,
    output logic       alu_bsel,
    output logic [1:0] alu_op,
    output logic [1:0] ext_op,
    output logic       dmwr,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MW    = 4'd4,
        S_MWB   = 4'd5,
        S_EXE   = 4'd6,
        S_AWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_rtype;
    logic w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic       w_alu_bsel;
    logic [1:0] w_alu_op;
    logic [1:0] w_ext_op;

    assign w_rtype = (op == c_OP_RTYPE);
    assign w_addu  = w_rtype && (funct == c_FN_ADDU);
    assign w_subu  = w_rtype && (funct == c_FN_SUBU);
    assign w_jr    = w_rtype && (funct == c_FN_JR);
    assign w_ori   = (op == c_OP_ORI);
    assign w_lw    = (op == c_OP_LW);
    assign w_sw    = (op == c_OP_SW);
    assign w_beq   = (op == c_OP_BEQ);
    assign w_lui   = (op == c_OP_LUI);
    assign w_j     = (op == c_OP_J);
    assign w_jal   = (op == c_OP_JAL);

    // ALU/extender settings shared by EXE and AWB so the result stays stable
    // through the write-back cycle.
    always_comb begin
        w_alu_bsel = 1'b0;
        w_alu_op   = 2'b00;
        w_ext_op   = 2'b00;
        if (w_subu) begin
            w_alu_op = 2'b01;
        end else if (w_ori) begin
            w_alu_bsel = 1'b1;
            w_alu_op   = 2'b10;
        end else if (w_lui) begin
            w_alu_bsel = 1'b1;
            w_alu_op   = 2'b11;
            w_ext_op   = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = S_FETCH;
        irwr     = 1'b0;
        pcwr     = 1'b0;
        npc_sel  = 2'b00;
        rfwr     = 1'b0;
        rf_wsel  = 2'b00;
        rf_dsel  = 2'b00;
        alu_bsel = 1'b0;
        alu_op   = 2'b00;
        ext_op   = 2'b00;
        dmwr     = 1'b0;
        illegal  = 1'b0;

        case (r_state)
            S_FETCH: begin
                irwr   = 1'b1;
                pcwr   = 1'b1;
                w_next = S_DCD;
            end
            S_DCD: begin
                if (w_lw || w_sw) begin
                    w_next = S_MA;
                end else if (w_addu || w_subu || w_ori || w_lui) begin
                    w_next = S_EXE;
                end else if (w_beq) begin
                    w_next = S_BR;
                end else if (w_j || w_jal || w_jr) begin
                    w_next = S_JMP;
                end else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MA: begin
                alu_bsel = 1'b1;
                ext_op   = 2'b01;
                w_next   = w_lw ? S_MR : S_MW;
            end
            S_MR: begin
                w_next = S_MWB;
            end
            S_MW: begin
                alu_bsel = 1'b1;
                ext_op   = 2'b01;
                dmwr     = 1'b1;
            end
            S_MWB: begin
                rfwr    = 1'b1;
                rf_dsel = 2'b01;
            end
            S_EXE: begin
                alu_bsel = w_alu_bsel;
                alu_op   = w_alu_op;
                ext_op   = w_ext_op;
                w_next   = S_AWB;
            end
            S_AWB: begin
                alu_bsel = w_alu_bsel;
                alu_op   = w_alu_op;
                ext_op   = w_ext_op;
                rfwr     = 1'b1;
                rf_wsel  = w_rtype ? 2'b01 : 2'b00;
            end
            S_BR: begin
                alu_op  = 2'b01;
                ext_op  = 2'b01;
                npc_sel = 2'b01;
                pcwr    = zero;
            end
            S_JMP: begin
                pcwr = 1'b1;
                if (w_jr) begin
                    npc_sel = 2'b11;
                end else begin
                    npc_sel = 2'b10;
                end
                if (w_jal) begin
                    rfwr    = 1'b1;
                    rf_wsel = 2'b10;
                    rf_dsel = 2'b10;
                end
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset suppresses every architectural write in the cycle it is seen.
        if (rst) begin
            irwr    = 1'b0;
            pcwr    = 1'b0;
            rfwr    = 1'b0;
            dmwr    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Directed, table-driven bench for mc_ctrl; each table row is
//                one clock cycle of inputs and expected outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BAD = 6'h3F;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       irwr, pcwr, rfwr, alu_bsel, dmwr, illegal;
    logic [1:0] npc_sel, rf_wsel, rf_dsel, alu_op, ext_op;
    logic [3:0] state;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .irwr     (irwr),
        .pcwr     (pcwr),
        .npc_sel  (npc_sel),
        .rfwr     (rfwr),
        .rf_wsel  (rf_wsel),
        .rf_dsel  (rf_dsel),
        .alu_bsel (alu_bsel),
        .alu_op   (alu_op),
        .ext_op   (ext_op),
        .dmwr     (dmwr),
        .illegal  (illegal),
        .state    (state)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected outputs packed as {state, irwr, pcwr, npc_sel, rfwr, rf_wsel,
    // rf_dsel, alu_bsel, alu_op, ext_op, dmwr, illegal}.
    function automatic void v(input logic r, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic [3:0] st,
                              input logic e_irwr, input logic e_pcwr, input logic [1:0] e_npc,
                              input logic e_rfwr, input logic [1:0] e_wsel,
                              input logic [1:0] e_dsel, input logic e_bsel,
                              input logic [1:0] e_aluop, input logic [1:0] e_ext,
                              input logic e_dmwr, input logic e_ill);
        vec_t t;
        t.rst   = r;
        t.op    = o;
        t.funct = f;
        t.zero  = z;
        t.exp   = {st, e_irwr, e_pcwr, e_npc, e_rfwr, e_wsel, e_dsel,
                   e_bsel, e_aluop, e_ext, e_dmwr, e_ill};
        vecs.push_back(t);
    endfunction

    function automatic void fr(input logic [5:0] o, input logic [5:0] f);
        v(1'b0, o, f, 1'b1, 4'd0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
    endfunction

    function automatic void dr(input logic [5:0] o, input logic [5:0] f);
        v(1'b0, o, f, 1'b1, 4'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
    endfunction

    function automatic logic [19:0] observed();
        return {state, irwr, pcwr, npc_sel, rfwr, rf_wsel, rf_dsel,
                alu_bsel, alu_op, ext_op, dmwr, illegal};
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [19:0] got, input logic [19:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %05h, required %05h", name, idx, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int idx, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %0d, required %0d", name, idx, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         cpi;
    } cpi_t;

    initial begin
        cpi_t cpis[10];
        int   cycles;

        //        rst op     funct   z  st irwr pcwr npc rfwr wsel dsel bsel aluop ext dmwr ill
        // reset held: state 0, all enables forced low
        v(1, OP_R, F_ADDU, 1, 4'd0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        v(1, OP_R, F_ADDU, 1, 4'd0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        // addu
        fr(OP_R, F_ADDU); dr(OP_R, F_ADDU);
        v(0, OP_R, F_ADDU, 1, 4'd6, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        v(0, OP_R, F_ADDU, 1, 4'd7, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        // subu
        fr(OP_R, F_SUBU); dr(OP_R, F_SUBU);
        v(0, OP_R, F_SUBU, 0, 4'd6, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd1, 2'd0, 0, 0);
        v(0, OP_R, F_SUBU, 0, 4'd7, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 2'd1, 2'd0, 0, 0);
        // ori
        fr(OP_ORI, 6'h00); dr(OP_ORI, 6'h00);
        v(0, OP_ORI, 6'h00, 0, 4'd6, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0, 0);
        v(0, OP_ORI, 6'h00, 0, 4'd7, 0, 0, 2'd0, 1, 2'd0, 2'd0, 1, 2'd2, 2'd0, 0, 0);
        // lui
        fr(OP_LUI, 6'h21); dr(OP_LUI, 6'h21);
        v(0, OP_LUI, 6'h21, 0, 4'd6, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd3, 2'd2, 0, 0);
        v(0, OP_LUI, 6'h21, 0, 4'd7, 0, 0, 2'd0, 1, 2'd0, 2'd0, 1, 2'd3, 2'd2, 0, 0);
        // lw
        fr(OP_LW, 6'h00); dr(OP_LW, 6'h00);
        v(0, OP_LW, 6'h00, 0, 4'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0, 0);
        v(0, OP_LW, 6'h00, 0, 4'd3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        v(0, OP_LW, 6'h00, 0, 4'd5, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0, 2'd0, 2'd0, 0, 0);
        // sw
        fr(OP_SW, 6'h00); dr(OP_SW, 6'h00);
        v(0, OP_SW, 6'h00, 1, 4'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0, 0);
        v(0, OP_SW, 6'h00, 1, 4'd4, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 1, 0);
        // beq taken, then not taken
        fr(OP_BEQ, 6'h00); dr(OP_BEQ, 6'h00);
        v(0, OP_BEQ, 6'h00, 1, 4'd8, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0, 2'd1, 2'd1, 0, 0);
        fr(OP_BEQ, 6'h00); dr(OP_BEQ, 6'h00);
        v(0, OP_BEQ, 6'h00, 0, 4'd8, 0, 0, 2'd1, 0, 2'd0, 2'd0, 0, 2'd1, 2'd1, 0, 0);
        // j, jal, jr
        fr(OP_J, 6'h00); dr(OP_J, 6'h00);
        v(0, OP_J, 6'h00, 0, 4'd9, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        fr(OP_JAL, 6'h00); dr(OP_JAL, 6'h00);
        v(0, OP_JAL, 6'h00, 0, 4'd9, 0, 1, 2'd2, 1, 2'd2, 2'd2, 0, 2'd0, 2'd0, 0, 0);
        fr(OP_R, F_JR); dr(OP_R, F_JR);
        v(0, OP_R, F_JR, 0, 4'd9, 0, 1, 2'd3, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        // illegal opcode and unsupported R-type funct
        fr(OP_BAD, 6'h00);
        v(0, OP_BAD, 6'h00, 0, 4'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 1);
        fr(OP_R, F_ADD);
        v(0, OP_R, F_ADD, 0, 4'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 1);
        // reset in MW: no store, back to FETCH
        fr(OP_SW, 6'h00); dr(OP_SW, 6'h00);
        v(0, OP_SW, 6'h00, 0, 4'd2, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0, 0);
        v(1, OP_SW, 6'h00, 0, 4'd4, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 2'd1, 0, 0);
        // reset in JMP for jal: no PC or register write
        fr(OP_JAL, 6'h00); dr(OP_JAL, 6'h00);
        v(1, OP_JAL, 6'h00, 1, 4'd9, 0, 0, 2'd2, 0, 2'd2, 2'd2, 0, 2'd0, 2'd0, 0, 0);
        // reset in DCD with illegal op: pulse suppressed
        fr(OP_BAD, 6'h00);
        v(1, OP_BAD, 6'h00, 0, 4'd1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        fr(OP_R, F_ADDU);

        rst   = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            #1;
            check("vec", i, observed(), vecs[i].exp);
        end

        // Cycles per instruction: count FETCH-to-FETCH from a fresh reset.
        cpis[0] = '{OP_R,   F_ADDU, 4};
        cpis[1] = '{OP_R,   F_SUBU, 4};
        cpis[2] = '{OP_ORI, 6'h00,  4};
        cpis[3] = '{OP_LUI, 6'h00,  4};
        cpis[4] = '{OP_LW,  6'h00,  5};
        cpis[5] = '{OP_SW,  6'h00,  4};
        cpis[6] = '{OP_BEQ, 6'h00,  3};
        cpis[7] = '{OP_J,   6'h00,  3};
        cpis[8] = '{OP_JAL, 6'h00,  3};
        cpis[9] = '{OP_R,   F_JR,   3};

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (cpis[k]) begin
            op     = cpis[k].op;
            funct  = cpis[k].funct;
            zero   = 1'b1;
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (state != 4'd0 && cycles < 12);
            check_int("cpi", k, cycles, cpis[k].cpi);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the MIPS core. It sequences instruction fetch, decode, execute, memory and write-back. It drives the write enables and mux selects for the instruction register, PC/NPC, register file, ALU, extender and data memory. Opcode and funct come from the instruction register's output. The IR's `irwr` is generated here and is asserted only in the fetch state.

## Interface
Parameters:
- none (state encoding fixed below)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset, sampled on rising edge of `clk`
- `op`  in  6  instruction[31:26] from IR output
- `funct`  in  6  instruction[5:0] from IR output
- `zero`  in  1  ALU zero flag (A == B)
- `irwr`  out  1  IR write enable
- `pcwr`  out  1  PC write enable
- `npc_sel`  out  2  00 PC+4, 01 PC+4+(sext(imm)<<2), 10 {PC[31:28],instr_index,2'b00}, 11 GPR[rs]
- `rfwr`  out  1  register file write enable
- `rf_wsel`  out  2  write address: 00 rt, 01 rd, 10 $31
- `rf_dsel`  out  2  write data: 00 ALU result, 01 DM data, 10 PC (already PC+4)
- `alu_bsel`  out  1  ALU B: 0 GPR[rt], 1 extender output
- `alu_op`  out  2  00 add, 01 sub, 10 or, 11 pass-B
- `ext_op`  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- `dmwr`  out  1  data memory write enable
- `illegal`  out  1  one-cycle pulse in DCD for unsupported instruction
- `state`  out  4  current state, for debug

## Operation
Supported instructions:
- R-type (`op`=000000): addu funct 100001, subu 100011, jr 001000
- I-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111
- J-type: j 000010, jal 000011

States and encodings, with transitions:
- FETCH=0: go to DCD.
- DCD=1: lw/sw go to MA. addu/subu/ori/lui go to EXE. beq goes to BR. j/jal/jr go to JMP. Anything else pulses `illegal` and goes to FETCH.
- MA=2: `alu_bsel`=1, `ext_op`=01, `alu_op`=00. lw goes to MR; sw goes to MW.
- MR=3: goes to MWB. MW=4: goes to FETCH. MWB=5: goes to FETCH.
- EXE=6: goes to AWB. AWB=7: goes to FETCH.
- BR=8: goes to FETCH. JMP=9: goes to FETCH.
- Codes 10–15 are unused and go to FETCH with all enables 0.

Output decode: Moore on `state`, plus `op`/`funct` where noted. Every signal not listed is 0.
- FETCH: `irwr`=1, `pcwr`=1, `npc_sel`=00.
- MW: `dmwr`=1, with the MA settings held.
- MWB: `rfwr`=1, `rf_wsel`=00, `rf_dsel`=01.
- EXE/AWB ALU settings:
  - addu: `alu_bsel`=0, `alu_op`=00.
  - subu: `alu_bsel`=0, `alu_op`=01.
  - ori: `alu_bsel`=1, `ext_op`=00, `alu_op`=10.
  - lui: `alu_bsel`=1, `ext_op`=10, `alu_op`=11.
- AWB write-back: `rfwr`=1, `rf_dsel`=00. `rf_wsel`=01 for R-type, 00 for ori/lui.
- BR: `alu_bsel`=0, `alu_op`=01, `ext_op`=01, `npc_sel`=01, `pcwr`=`zero`.
- JMP: `pcwr`=1.
  - j: `npc_sel`=10.
  - jal: `npc_sel`=10, `rfwr`=1, `rf_wsel`=10, `rf_dsel`=10.
  - jr: `npc_sel`=11.

Reset:
- While `rst`=1, `irwr`, `pcwr`, `rfwr`, `dmwr` and `illegal` are forced to 0.
- Next edge with `rst`=1: `state` becomes FETCH (0).
- Reset asserted in any state, mid-instruction, aborts the instruction. No partial write occurs in the reset cycle.

## Timing
- `op`/`funct` are valid from DCD onward; the IR captures at the FETCH edge. They are never used in FETCH.
- Cycles per instruction:
  - addu/subu/ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
- `pcwr` in FETCH updates PC to PC+4 at the FETCH→DCD edge. Branch and jump targets use that incremented PC.
- `zero` is sampled combinationally in BR only.
- The first cycle after reset release is FETCH, with `irwr`=1.

## Test plan
- Reset then release:
  - With `rst`=1 for 2 cycles, `state`=0 and all enables are 0.
  - First cycle after release: `irwr`=1, `pcwr`=1.
- addu (`op`=0, `funct`=100001):
  - State sequence 0,1,6,7,0.
  - In AWB: `rfwr`=1, `rf_wsel`=01, `alu_op`=00.
- lw (`op`=100011):
  - State sequence 0,1,2,3,5,0.
  - In MWB: `rf_dsel`=01, `rf_wsel`=00.
- sw (`op`=101011): state sequence 0,1,2,4,0, with `dmwr`=1 only in state 4.
- beq (`op`=000100):
  - With `zero`=1: `pcwr`=1 and `npc_sel`=01 in state 8.
  - With `zero`=0: `pcwr`=0.
- jal (`op`=000011): in state 9, `pcwr`=1, `rfwr`=1, `rf_wsel`=10, `rf_dsel`=10.
- `op`=111111: `illegal`=1 in DCD for one cycle, then the next state is 0.
- `rst` asserted in MW: `dmwr`=0 that cycle, and `state`=0 on the next edge.
